// File: rtl/mux_pkg.sv
// Shared constants and buffer-state type for the select-mux pipeline.
// Used by mux_sel_n and sel_mux_pipe.
package mux_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/mux_sel_n.sv
// Combinational N-way channel select.
// An index with no matching channel yields all-zero data.
module mux_sel_n
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [WIDTH-1:0]        out_data
);

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/sel_mux_pipe.sv
// Channel select feeding a 2-entry skid buffer with registered in_ready.
// Define SEL_MUX_PIPE_SEL_ERR_EN to enable the sticky sel_err flag.
module sel_mux_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] sel_data;
  logic             in_fire;
  logic             out_fire;

  mux_sel_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_data (sel_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = sel_data;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          in_fire && !out_fire: begin
            skid_d  = sel_data;
            state_d = FULL;
          end
          in_fire && out_fire: begin
            main_d = sel_data;
          end
          !in_fire && out_fire: begin
            state_d = EMPTY;
          end
          default: ;
        endcase
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Registered ready: next-cycle acceptance depends only on the next state.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef SEL_MUX_PIPE_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  always_comb begin
    sel_err_d = sel_err_q | (in_fire && (32'(in_sel) >= NUM_IN));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Randomized bench for sel_mux_pipe with a queue-based reference model.
// Uses NUM_IN=3 so that in_sel=3 exercises the out-of-range path.
module tb_sel_mux_pipe;

  localparam int W  = 32;
  localparam int NI = 3;
`ifdef SEL_MUX_PIPE_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic [NI*W-1:0] in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          sel_err;

  sel_mux_pipe #(
    .WIDTH  (W),
    .NUM_IN (NI)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  bit rnd_mode = 1'b0;

  logic [W-1:0] q[$];
  bit acc_flag = 1'b0;
  bit err_exp = 1'b0;
  int dut_out_cnt = 0;
  logic [W-1:0] last_out = '0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [NI*W-1:0] d,
                                        input int s);
    if (s < NI) return d[s*W +: W];
    return '0;
  endfunction

  // Reference model: FIFO of accepted beats, capacity two.
  initial forever begin
    bit ir, ov, inf, outf;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      q.delete();
      acc_flag = 1'b0;
      err_exp = 1'b0;
    end else begin
      ir = (q.size() < 2);
      ov = (q.size() > 0);
      inf = in_valid && ir;
      outf = ov && out_ready;
      if (outf) void'(q.pop_front());
      if (inf) begin
        q.push_back(pick(in_data, int'(in_sel)));
        if (int'(in_sel) >= NI && ERR_EN) err_exp = 1'b1;
      end
      acc_flag = inf;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("sel_err", 64'(sel_err), 64'(err_exp));
      if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0]));
    end
  end

  // Observed output transfers, sampled late in the low phase.
  initial forever begin
    @(negedge clk);
    #4;
    if (reset_n && out_valid && out_ready) begin
      dut_out_cnt++;
      last_out = out_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [NI*W-1:0] d, input logic [1:0] s);
    int n;
    in_data = d;
    in_sel = s;
    in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_flag && n < 500);
    chk("send_accept", 64'(acc_flag), 64'd1);
  endtask

  function automatic logic [NI*W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [NI*W-1:0] d;
    int t0, c0;
    reset_n = 1'b0;
    in_data = '0;
    in_sel = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_sel_err", 64'(sel_err), 64'd0);
    #2 reset_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Single beat on channel 2
    d = rnd_data();
    d[2*W +: W] = 32'hDEADBEEF;
    send(d, 2'd2);
    in_valid = 1'b0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'hDEADBEEF);
    tick();
    chk("single_gone", 64'(out_valid), 64'd0);

    // Backpressure: fill both entries, third beat must wait
    out_ready = 1'b0;
    d = rnd_data(); d[0 +: W] = 32'h11; send(d, 2'd0);
    d = rnd_data(); d[W +: W] = 32'h22; send(d, 2'd1);
    d = rnd_data(); d[2*W +: W] = 32'h33;
    in_data = d; in_sel = 2'd2; in_valid = 1'b1;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    repeat (3) tick();
    chk("c_held", 64'(acc_flag), 64'd0);
    chk("c_held_rdy", 64'(in_ready), 64'd0);
    chk("ord_a", 64'(out_data), 64'h11);
    out_ready = 1'b1;
    tick();
    chk("ord_b", 64'(out_data), 64'h22);
    tick();
    chk("c_taken", 64'(acc_flag), 64'd1);
    chk("ord_c", 64'(out_data), 64'h33);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Streaming: one beat per cycle
    t0 = cyc;
    for (int i = 0; i < 100; i++) send(rnd_data(), 2'($urandom_range(0, NI - 1)));
    in_valid = 1'b0;
    chk("stream_cycles", 64'(cyc - t0), 64'd100);
    repeat (2) tick();

    // Out-of-range select
    send(rnd_data(), 2'd3);
    chk("oor_data", 64'(out_data), 64'd0);
    chk("oor_err", 64'(sel_err), 64'(ERR_EN));
    send(rnd_data(), 2'd0);
    in_valid = 1'b0;
    repeat (2) tick();
    chk("oor_err_sticky", 64'(sel_err), 64'(ERR_EN));

    // Random backpressure, 1000 beats including out-of-range selects
    c0 = dut_out_cnt;
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) send(rnd_data(), 2'($urandom_range(0, 3)));
    in_valid = 1'b0;
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("rnd_count", 64'(dut_out_cnt - c0), 64'd1000);
    chk("rnd_drained", 64'(out_valid), 64'd0);

    // Reset while FULL
    out_ready = 1'b0;
    send(rnd_data(), 2'd0);
    send(rnd_data(), 2'd1);
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    #2;
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_err", 64'(sel_err), 64'd0);
    tick();
    #2 reset_n = 1'b1;
    c0 = dut_out_cnt;
    tick();
    out_ready = 1'b1;
    d = rnd_data(); d[W +: W] = 32'h55;
    send(d, 2'd1);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("post_rst_count", 64'(dut_out_cnt - c0), 64'd1);
    chk("post_rst_data", 64'(last_out), 64'h55);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
